// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: protocol constants, header ECC, CRC-16 step and
// the transmit state encoding.
package csi2_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hB8;
  localparam logic [5:0]  DT_FS     = 6'h00;
  localparam logic [5:0]  DT_FE     = 6'h01;
  localparam logic [5:0]  DT_RAW8   = 6'h2A;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC_POLY  = 16'h8408;  // x^16+x^12+x^5+1, reflected

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_SYNC,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_CRC,
    ST_TRAIL
  } tx_state_t;

  // Data types below 0x10 are short packets.
  function automatic logic is_long_dt(input logic [5:0] dt);
    return dt[5:4] != 2'b00;
  endfunction

  // Header ECC over {WC_H, WC_L, DI}; each mask selects the header bits
  // feeding one parity bit, identical to the receive-side check.
  function automatic logic [7:0] csi2_ecc(input logic [23:0] hdr);
    logic [7:0] ecc;
    ecc    = 8'h00;
    ecc[0] = ^(hdr & 24'hF12CB7);
    ecc[1] = ^(hdr & 24'hF2555B);
    ecc[2] = ^(hdr & 24'h749A6D);
    ecc[3] = ^(hdr & 24'hB8E38E);
    ecc[4] = ^(hdr & 24'hDF03F0);
    ecc[5] = ^(hdr & 24'hEFFC00);
    return ecc;
  endfunction

  // One byte of the reflected CRC-16, LSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Trail level: the opposite of the last transmitted bit on that lane.
  function automatic logic [7:0] trail_fill(input logic [7:0] last_byte);
    return last_byte[7] ? 8'h00 : 8'hFF;
  endfunction

endpackage

// File: rtl/csi2_crc16.sv
// Two-byte-per-cycle CSI-2 payload CRC: data[7:0] is folded in before
// data[15:8]. Shared with the receive-side checker.
module csi2_crc16
  import csi2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] data,
  output logic [15:0] crc
);

  // Accumulate one payload word per enabled cycle; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples values from before the edge, independent of block ordering.
    if (rst) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc_step(crc_step(crc, data[7:0]), data[15:8]);
    end
  end

endmodule

// File: rtl/csi2_packet_tx.sv
// Two-lane CSI-2 packet transmitter: HS-zero, sync, header+ECC, payload,
// CRC-16 and trail, byte n of the packet on lane n mod 2. Every output is a
// register loaded from the value computed for the state being entered.
module csi2_packet_tx
  import csi2_pkg::*;
#(
  parameter int PREP_CYCLES  = 4,
  parameter int TRAIL_CYCLES = 2
) (
  input  logic        mipi_clk,
  input  logic        reset,
  input  logic        pkt_start,
  output logic        pkt_ready,
  input  logic [5:0]  pkt_dt,
  input  logic [1:0]  pkt_vc,
  input  logic [15:0] pkt_wc,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [7:0]  lane0_byte,
  output logic [7:0]  lane1_byte,
  output logic        hs_valid,
  output logic        pkt_done,
  output logic        pkt_err
);

  // PREP is entered one cycle before HS-zero starts, so its count is one longer.
  localparam logic [15:0] PREP_LOAD  = 16'(PREP_CYCLES);
  localparam logic [15:0] TRAIL_LOAD = 16'(TRAIL_CYCLES - 1);

  tx_state_t   state, state_d;
  logic [15:0] cyc_cnt, cyc_cnt_d;
  logic [14:0] words_left, words_left_d;
  logic [7:0]  di, di_d, ecc, ecc_d;
  logic [15:0] wc, wc_d;
  logic        long_pkt, long_pkt_d;
  logic [7:0]  lane0_d, lane1_d;
  logic        hs_d, ready_d, dr_d, done_d, err_d;
  logic        crc_clear, crc_enable;
  logic [15:0] crc_value;
  logic [15:0] payload_word;

  // An underrun sends zeros, which are also what the CRC sees.
  assign payload_word = data_valid ? data_in : 16'h0000;

  csi2_crc16 u_crc (
    .clk    (mipi_clk),
    .rst    (reset),
    .clear  (crc_clear),
    .enable (crc_enable),
    .data   (payload_word),
    .crc    (crc_value)
  );

  // State, captured header and registered outputs.
  always_ff @(posedge mipi_clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cyc_cnt    <= '0;
      words_left <= '0;
      di         <= '0;
      wc         <= '0;
      ecc        <= '0;
      long_pkt   <= 1'b0;
      lane0_byte <= '0;
      lane1_byte <= '0;
      hs_valid   <= 1'b0;
      pkt_ready  <= 1'b1;
      data_ready <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      state      <= state_d;
      cyc_cnt    <= cyc_cnt_d;
      words_left <= words_left_d;
      di         <= di_d;
      wc         <= wc_d;
      ecc        <= ecc_d;
      long_pkt   <= long_pkt_d;
      lane0_byte <= lane0_d;
      lane1_byte <= lane1_d;
      hs_valid   <= hs_d;
      pkt_ready  <= ready_d;
      data_ready <= dr_d;
      pkt_done   <= done_d;
      pkt_err    <= err_d;
    end
  end

  // Next state and the output values that go with it.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state;
    cyc_cnt_d    = cyc_cnt;
    words_left_d = words_left;
    di_d         = di;
    wc_d         = wc;
    ecc_d        = ecc;
    long_pkt_d   = long_pkt;
    lane0_d      = 8'h00;
    lane1_d      = 8'h00;
    hs_d         = 1'b0;
    ready_d      = 1'b0;
    dr_d         = 1'b0;
    done_d       = 1'b0;
    err_d        = pkt_err;
    crc_clear    = 1'b0;
    crc_enable   = 1'b0;

    case (state)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (pkt_start && pkt_ready) begin
          if (is_long_dt(pkt_dt) && pkt_wc[0]) begin
            err_d = 1'b1;                       // odd long WC: reject, stay idle
          end else begin
            state_d      = ST_PREP;
            ready_d      = 1'b0;
            err_d        = 1'b0;
            cyc_cnt_d    = PREP_LOAD;
            di_d         = {pkt_vc, pkt_dt};
            wc_d         = pkt_wc;
            ecc_d        = csi2_ecc({pkt_wc, pkt_vc, pkt_dt});
            long_pkt_d   = is_long_dt(pkt_dt);
            words_left_d = pkt_wc[15:1];
            crc_clear    = 1'b1;
          end
        end
      end
      ST_PREP: begin
        hs_d = 1'b1;
        if (cyc_cnt == '0) begin
          state_d = ST_SYNC;
          lane0_d = SYNC_BYTE;
          lane1_d = SYNC_BYTE;
        end else begin
          cyc_cnt_d = cyc_cnt - 16'd1;
        end
      end
      ST_SYNC: begin
        hs_d    = 1'b1;
        state_d = ST_HDR0;
        lane0_d = di;
        lane1_d = wc[7:0];
      end
      ST_HDR0: begin
        hs_d    = 1'b1;
        state_d = ST_HDR1;
        lane0_d = wc[15:8];
        lane1_d = ecc;
        dr_d    = long_pkt && (words_left != '0);
      end
      ST_HDR1, ST_PAYLOAD: begin
        hs_d = 1'b1;
        if ((state == ST_HDR1) && !long_pkt) begin
          state_d   = ST_TRAIL;
          lane0_d   = trail_fill(lane0_byte);
          lane1_d   = trail_fill(lane1_byte);
          cyc_cnt_d = TRAIL_LOAD;
        end else if (words_left != '0) begin
          state_d      = ST_PAYLOAD;
          words_left_d = words_left - 15'd1;
          lane0_d      = payload_word[7:0];
          lane1_d      = payload_word[15:8];
          dr_d         = (words_left != 15'd1);
          crc_enable   = 1'b1;
          if (!data_valid) err_d = 1'b1;
        end else begin
          state_d = ST_CRC;
          lane0_d = crc_value[7:0];
          lane1_d = crc_value[15:8];
        end
      end
      ST_CRC: begin
        hs_d      = 1'b1;
        state_d   = ST_TRAIL;
        lane0_d   = trail_fill(lane0_byte);
        lane1_d   = trail_fill(lane1_byte);
        cyc_cnt_d = TRAIL_LOAD;
      end
      ST_TRAIL: begin
        if (cyc_cnt == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          hs_d      = 1'b1;
          lane0_d   = lane0_byte;
          lane1_d   = lane1_byte;
          cyc_cnt_d = cyc_cnt - 16'd1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_csi2_packet_tx.sv
// Directed bench for csi2_packet_tx: each packet is described by its
// hand-computed header/ECC and payload; the expected per-cycle lane stream
// is laid out in a table and compared cycle by cycle on the falling edge.
module tb_csi2_packet_tx;
  import csi2_pkg::*;

  localparam int PREP  = 4;
  localparam int TRAIL = 2;

  logic        mipi_clk = 1'b0;
  logic        reset;
  logic        pkt_start;
  logic        pkt_ready;
  logic [5:0]  pkt_dt;
  logic [1:0]  pkt_vc;
  logic [15:0] pkt_wc;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  lane0_byte;
  logic [7:0]  lane1_byte;
  logic        hs_valid;
  logic        pkt_done;
  logic        pkt_err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] words [16];

  typedef struct {
    logic [7:0] l0;
    logic [7:0] l1;
    logic       hs;
    logic       dr;
    logic       rdy;
    logic       done;
    logic       err;
    int         widx;
  } exp_t;

  csi2_packet_tx #(.PREP_CYCLES(PREP), .TRAIL_CYCLES(TRAIL)) dut (
    .mipi_clk   (mipi_clk),
    .reset      (reset),
    .pkt_start  (pkt_start),
    .pkt_ready  (pkt_ready),
    .pkt_dt     (pkt_dt),
    .pkt_vc     (pkt_vc),
    .pkt_wc     (pkt_wc),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .lane0_byte (lane0_byte),
    .lane1_byte (lane1_byte),
    .hs_valid   (hs_valid),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err)
  );

  always #5 mipi_clk = ~mipi_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input logic [7:0] l0, input logic [7:0] l1, input logic hs,
                              input logic dr, input logic rdy, input logic done,
                              input logic err, input int widx);
    exp_t e;
    e.l0 = l0; e.l1 = l1; e.hs = hs; e.dr = dr;
    e.rdy = rdy; e.done = done; e.err = err; e.widx = widx;
    return e;
  endfunction

  // Vector layout: {hs_valid, data_ready, pkt_ready, pkt_done, pkt_err, lane1, lane0}
  function automatic logic [20:0] pack(input exp_t e);
    return {e.hs, e.dr, e.rdy, e.done, e.err, e.l1, e.l0};
  endfunction

  function automatic logic [20:0] observed();
    return {hs_valid, data_ready, pkt_ready, pkt_done, pkt_err, lane1_byte, lane0_byte};
  endfunction

  // Bit-serial LFSR form of the reflected CRC-16 (0x8408), LSB first.
  function automatic logic [15:0] crc_ser(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (hs,dr,rdy,done,err,l1,l0)", tag, obs, exp);
    end
  endtask

  // Launch one packet and compare every cycle from the accept edge to one
  // cycle past pkt_done. stop_at>0 aborts after that many compared cycles.
  task automatic run_pkt(input string name, input logic [5:0] dt, input logic [1:0] vc,
                         input logic [15:0] wc, input logic [7:0] ecc_hand,
                         input int underrun, input bit crc_given, input logic [15:0] crc_hand,
                         input bit hold_start, input int stop_at);
    exp_t        q[$];
    logic        is_long;
    int          nw;
    logic        err;
    logic [15:0] crc_m;
    logic [15:0] w;
    logic [7:0]  last0, last1;

    is_long = (dt >= 6'h10);
    nw      = is_long ? int'(wc[15:1]) : 0;
    err     = 1'b0;
    crc_m   = 16'hFFFF;

    q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1));
    repeat (PREP) q.push_back(mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1));
    q.push_back(mk(8'hB8, 8'hB8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1));
    q.push_back(mk({vc, dt}, wc[7:0], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1));
    q.push_back(mk(wc[15:8], ecc_hand, 1'b1, is_long && (nw > 0), 1'b0, 1'b0, 1'b0, -1));
    last0 = wc[15:8];
    last1 = ecc_hand;
    if (is_long) begin
      for (int i = 0; i < nw; i++) begin
        w = (i == underrun) ? 16'h0000 : words[i];
        if (i == underrun) err = 1'b1;
        crc_m = crc_ser(crc_ser(crc_m, w[7:0]), w[15:8]);
        q.push_back(mk(w[7:0], w[15:8], 1'b1, i < nw - 1, 1'b0, 1'b0, err, i));
      end
      if (crc_given) crc_m = crc_hand;
      q.push_back(mk(crc_m[7:0], crc_m[15:8], 1'b1, 1'b0, 1'b0, 1'b0, err, -1));
      last0 = crc_m[7:0];
      last1 = crc_m[15:8];
    end
    repeat (TRAIL) q.push_back(mk(last0[7] ? 8'h00 : 8'hFF, last1[7] ? 8'h00 : 8'hFF,
                                  1'b1, 1'b0, 1'b0, 1'b0, err, -1));
    q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, err, -1));
    q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, err, -1));

    pkt_start = 1'b1;
    pkt_dt    = dt;
    pkt_vc    = vc;
    pkt_wc    = wc;
    for (int j = 0; j < q.size(); j++) begin
      if (j == 1) begin
        // Header inputs change after acceptance; the packet must not notice.
        pkt_start = hold_start;
        pkt_dt    = ~dt;
        pkt_vc    = ~vc;
        pkt_wc    = ~wc;
      end
      if (j == q.size() - 1) pkt_start = 1'b0;
      if (q[j].widx >= 0) begin
        data_in    = words[q[j].widx];
        data_valid = (q[j].widx != underrun);
      end else begin
        data_in    = 16'hA5C3;
        data_valid = 1'b1;
      end
      @(posedge mipi_clk);
      @(negedge mipi_clk);
      check($sformatf("%s[%0d]", name, j), observed(), pack(q[j]));
      if (stop_at > 0 && j + 1 == stop_at) break;
    end
    pkt_start  = 1'b0;
    data_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    pkt_start  = 1'b0;
    pkt_dt     = '0;
    pkt_vc     = '0;
    pkt_wc     = '0;
    data_in    = '0;
    data_valid = 1'b0;

    // Reset values appear asynchronously.
    #2 reset = 1'b1;
    #1 check("reset_async", observed(), pack(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1)));
    repeat (3) @(negedge mipi_clk);
    reset = 1'b0;
    @(negedge mipi_clk);
    check("reset_idle", observed(), pack(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1)));

    // Short frame start, pkt_start held high throughout.
    run_pkt("fs", DT_FS, 2'd0, 16'h0000, 8'h00, -1, 1'b0, 16'h0000, 1'b1, 0);

    // RAW8, WC=4.
    words[0] = 16'h1100; words[1] = 16'h3322;
    run_pkt("raw8", DT_RAW8, 2'd0, 16'h0004, 8'h33, -1, 1'b0, 16'h0000, 1'b0, 0);

    // Reference CRC vector, CRC = 0x00F0.
    words[0] = 16'h00FF; words[1]  = 16'h0200; words[2]  = 16'hDCB9; words[3]  = 16'h72F3;
    words[4] = 16'hD4BB; words[5]  = 16'h5AB8; words[6]  = 16'h75C8; words[7]  = 16'h7CC2;
    words[8] = 16'hF881; words[9]  = 16'hDF05; words[10] = 16'h00FF; words[11] = 16'h0100;
    run_pkt("crc24", DT_RAW8, 2'd0, 16'd24, 8'h13, -1, 1'b1, 16'h00F0, 1'b0, 0);

    // Odd long WC is rejected.
    pkt_start = 1'b1;
    pkt_dt    = DT_RAW8;
    pkt_vc    = 2'd0;
    pkt_wc    = 16'h0003;
    @(posedge mipi_clk);
    @(negedge mipi_clk);
    pkt_start = 1'b0;
    check("odd_wc", observed(), pack(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1)));
    @(posedge mipi_clk);
    @(negedge mipi_clk);
    check("odd_wc_hold", observed(), pack(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1)));

    // Underrun on the third word; accept clears the previous error.
    words[0] = 16'h1100; words[1] = 16'h3322; words[2] = 16'h5544; words[3] = 16'h7766;
    run_pkt("underrun", DT_RAW8, 2'd0, 16'h0008, 8'h35, 2, 1'b0, 16'h0000, 1'b0, 0);

    // Long packet with WC=0: no payload, CRC is the init value.
    run_pkt("wc0", DT_RAW8, 2'd0, 16'h0000, 8'h10, -1, 1'b1, 16'hFFFF, 1'b0, 0);

    // Short frame end on VC 2 carrying an odd data field.
    run_pkt("fe", DT_FE, 2'd2, 16'h1235, 8'h05, -1, 1'b0, 16'h0000, 1'b0, 0);

    // Reset in the middle of the payload, then the same packet cleanly.
    run_pkt("pre_reset", DT_RAW8, 2'd0, 16'h0008, 8'h35, -1, 1'b0, 16'h0000, 1'b0, 10);
    #2 reset = 1'b1;
    #1 check("reset_mid", observed(), pack(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1)));
    @(posedge mipi_clk);
    @(negedge mipi_clk);
    reset = 1'b0;
    @(negedge mipi_clk);
    run_pkt("post_reset", DT_RAW8, 2'd0, 16'h0008, 8'h35, -1, 1'b0, 16'h0000, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csi2_packet_tx.md
# csi2_packet_tx

Two-lane MIPI CSI-2 packet transmitter. It builds short and long packets from a header request and a 16-bit payload stream, then emits per-lane HS byte streams in this order:

- HS-zero preamble
- sync byte 0xB8
- header with ECC
- payload
- CRC-16
- trail

It is the byte-level transmit counterpart to our 2-lane CSI-2 receive path and feeds the HS serializers / loopback bench. Byte n of a packet goes to lane n mod 2, LSB transmitted first.

## Interface
Parameters:
- PREP_CYCLES, 4: byte-clock cycles of 0x00 sent with hs_valid=1 before the sync byte (HS-zero).
- TRAIL_CYCLES, 2: byte-clock cycles of trail after the last packet byte.

Ports (one clock; reset is asynchronous and active-high):
- mipi_clk  in  1  byte clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pkt_start  in  1  header request valid.
- pkt_ready  out  1  block idle, request accepted when pkt_start&pkt_ready.
- pkt_dt  in  6  data type; values below 0x10 are short packets.
- pkt_vc  in  2  virtual channel.
- pkt_wc  in  16  long packet: byte count (must be even); short packet: data field.
- data_in  in  16  payload, [7:0]=lane0 byte, [15:8]=lane1 byte.
- data_valid  in  1  payload word valid.
- data_ready  out  1  payload word consumed this cycle.
- lane0_byte  out  8  lane 0 HS byte.
- lane1_byte  out  8  lane 1 HS byte.
- hs_valid  out  1  lanes in HS mode (drives HS request/termination on the PHY side).
- pkt_done  out  1  one-cycle pulse after the last trail cycle.
- pkt_err  out  1  sticky error (odd WC or payload underrun); cleared on the next accepted start.

## Operation
- Reset values:
  - pkt_ready=1
  - hs_valid=0, data_ready=0, pkt_done=0, pkt_err=0
  - lane0_byte=lane1_byte=0x00
  - state IDLE
- DI = {pkt_vc, pkt_dt}. Header bits [23:0] = {WC_H, WC_L, DI}.
- ECC bits 0..5 use the same parity equations as the receiver's header check; bits 6..7 are 0.
- Header lane split: lane0 = DI then WC_H; lane1 = WC_L then ECC.
- States and transitions:
  - IDLE → PREP on accepted start. A long packet with odd WC is instead rejected: pkt_err=1, stays IDLE.
  - PREP (PREP_CYCLES) → SYNC (1 cycle, 0xB8 on both lanes).
  - SYNC → HDR0 → HDR1 → PAYLOAD (long) or TRAIL (short).
  - PAYLOAD runs WC/2 cycles; WC=0 skips it.
  - PAYLOAD → CRC: 1 cycle, lane0 = CRC[7:0], lane1 = CRC[15:8].
  - CRC → TRAIL (TRAIL_CYCLES) → IDLE with a pkt_done pulse.
- Payload:
  - data_ready=1 on every PAYLOAD cycle.
  - Underrun (data_valid=0): both lanes emit 0x00, pkt_err set, the cycle still counts, and the CRC includes the 0x00 bytes. The stream never stalls.
- CRC-16:
  - Polynomial x^16+x^12+x^5+1, reflected (0x8408), init 0xFFFF, no final XOR.
  - Covers payload bytes only, processing lane0 then lane1 byte each cycle.
- Trail: each lane repeats 0xFF if bit 7 of its last byte was 0, else 0x00.
- Inputs captured at acceptance are held for the packet: DI, WC, ECC.
- pkt_start is ignored while not in IDLE.
- pkt_start coinciding with pkt_done is not accepted that cycle (pkt_ready=0 until IDLE).
- Reset mid-packet: all outputs take reset values immediately and the CRC is cleared; there is no trail.

## Timing
- All outputs are registered.
- Accept at edge 0:
  - hs_valid=1 and lane bytes 0x00 from edge 1.
  - Sync byte on edge 1+PREP_CYCLES.
  - Header on the next 2 edges.
- Payload: the word consumed at edge k appears on the lanes at edge k, with data_ready registered one cycle ahead.
- The CRC appears in the cycle immediately after the last payload word.
- pkt_done fires on the cycle hs_valid falls. pkt_ready returns the same cycle.
- Packet length in cycles = 1+PREP_CYCLES+1+2+WC/2+1+TRAIL_CYCLES (long) or 1+PREP_CYCLES+3+TRAIL_CYCLES (short).
- Word counter is 15 bits and counts down to zero; WC=0xFFFE is supported without wrap.

## Structure
- Package csi2_pkg:
  - Constants SYNC_BYTE=0xB8, DT_FS=0x00, DT_FE=0x01, DT_RAW8=0x2A, CRC_INIT=0xFFFF.
  - ECC function over 24 bits.
  - Single-byte CRC step function.
  - State encoding.
- Sub-module csi2_crc16: 2 bytes per cycle, with clear/enable. It is reused by the receive-side checker.

## Test plan
- Short FS packet: VC=0, DT=0x00, WC=0x0000 with defaults.
  - Response: 4×(0x00,0x00), (0xB8,0xB8), (0x00,0x00), (0x00,0x00), trail 2×(0xFF,0xFF), then pkt_done.
- RAW8 long packet: DT=0x2A, WC=0x0004, data 0x1100, 0x3322.
  - Header: lane0 0x2A, 0x00; lane1 0x04, ECC=0x33.
  - Payload: lane0 0x00, 0x22; lane1 0x11, 0x33.
  - Followed by CRC, then trail.
- CRC check: WC=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01.
  - Response: CRC cycle lane0=0xF0, lane1=0x00.
- Underrun: data_valid dropped for 1 cycle mid-payload.
  - Response: lanes 0x00 that cycle, pkt_err=1, packet length unchanged, CRC computed over the zeros.
- Odd WC=0x0003 with DT=0x2A.
  - Response: pkt_err=1, hs_valid stays 0, pkt_ready stays 1.
- Reset asserted during PAYLOAD.
  - Response: hs_valid=0 and lanes 0x00 without a clock edge.
  - A next packet started after reset release is bit-exact to a clean run.
